// File: rtl/store_narrow_unit_32to8_pkg.sv
// Shared constants for the byte-serialising store unit: RV32 store funct3 codes
// and the controller state encoding.
package store_narrow_unit_32to8_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/store_narrow_unit_32to8_if.sv
// Request/response and byte-wide memory port bundle for store_narrow_unit_32to8.
// master = core/memory environment side, slave = the store unit.
interface store_narrow_unit_32to8_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              start;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ready;

    modport master (
        output start, funct3, addr, wdata, mem_ready,
        input  busy, done, err, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  start, funct3, addr, wdata, mem_ready,
        output busy, done, err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_narrow_unit_32to8_store_size_decode.sv
// Combinational decode of store funct3 and low address bits into a byte count
// and an error flag (illegal funct3 or, optionally, misalignment).
module store_size_decode
    import store_narrow_unit_32to8_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_lo_i,
    output logic [2:0] nbytes_o,
    output logic       err_o
);

    always_comb begin
        nbytes_o = 3'd1;
        err_o    = 1'b0;
        case (funct3_i)
            F3_SB: nbytes_o = 3'd1;
            F3_SH: begin
                nbytes_o = 3'd2;
                err_o    = CHECK_ALIGN && addr_lo_i[0];
            end
            F3_SW: begin
                nbytes_o = 3'd4;
                err_o    = CHECK_ALIGN && (addr_lo_i != 2'b00);
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_narrow_unit_32to8.sv
// Serialises an SB/SH/SW store word onto a byte-wide write port, little-endian,
// one byte per accepted beat; busy stalls the core while the request is in flight.
module store_narrow_unit_32to8
    import store_narrow_unit_32to8_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input logic                         clk,
    input logic                         rst,
    store_narrow_unit_32to8_if.slave    bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [1:0]        idx_q, idx_d;
    logic              err_q, err_d;

    logic [2:0]        dec_nbytes;
    logic              dec_err;
    logic              last_beat;

    store_size_decode #(
        .CHECK_ALIGN (CHECK_ALIGN)
    ) u_decode (
        .funct3_i  (bus.funct3),
        .addr_lo_i (bus.addr[1:0]),
        .nbytes_o  (dec_nbytes),
        .err_o     (dec_err)
    );

    assign last_beat = ({1'b0, idx_q} == (nbytes_q - 3'd1));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        nbytes_d = nbytes_q;
        idx_d    = idx_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d   = bus.addr;
                    wdata_d  = bus.wdata;
                    nbytes_d = dec_nbytes;
                    idx_d    = 2'd0;
                    err_d    = dec_err;
                    state_d  = dec_err ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.mem_ready) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            nbytes_q <= 3'd0;
            idx_q    <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            nbytes_q <= nbytes_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    // Bus outputs are forced to zero outside WRITE so stale latched data never leaks.
    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_DONE);
        bus.err       = (state_q == S_DONE) && err_q;
        bus.mem_we    = (state_q == S_WRITE);
        bus.mem_addr  = '0;
        bus.mem_wdata = 8'h00;
        if (state_q == S_WRITE) begin
            bus.mem_addr  = addr_q + ADDR_W'(idx_q);
            bus.mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_store_narrow_unit_32to8.sv
// Randomised and directed bench for store_narrow_unit_32to8 against a queue-based
// model of the expected byte beats.
module tb_store_narrow_unit_32to8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    store_narrow_unit_32to8_if #(.ADDR_W(32)) bus ();

    store_narrow_unit_32to8 #(
        .ADDR_W      (32),
        .CHECK_ALIGN (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // mode 0: ready always 1 (latency checked); 1: random ready; 2: stall beat 0 for 3 cycles
    task automatic run_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           input int mode, input string tag);
        logic [31:0] q_addr[$];
        logic [7:0]  q_data[$];
        logic        exp_err;
        int          n;
        int          cyc;
        int          stall;
        bit          seen_done;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        exp_err = (f3 > 3'd2) || (f3 == 3'd1 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
        if (!exp_err) begin
            for (int k = 0; k < n; k++) begin
                q_addr.push_back(a + k);
                q_data.push_back(8'((d >> (8 * k)) & 32'hFF));
            end
        end
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
        bus.start     = 1'b1;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = d;
        bus.mem_ready = 1'b1;
        cyc       = 0;
        stall     = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            // Garbage on the request inputs: must be ignored after acceptance.
            bus.start  = 1'($urandom_range(0, 1));
            bus.funct3 = 3'($urandom_range(0, 2));
            bus.addr   = $urandom & 32'hFFFF_FFFC;
            bus.wdata  = $urandom;
            if (bus.done) begin
                seen_done = 1'b1;
                bus.start = 1'b0;
                check({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
                check({tag, "_remaining"}, q_addr.size(), 32'd0);
                if (mode == 0)
                    check({tag, "_latency"}, cyc, exp_err ? 32'd1 : 32'(n + 1));
            end else begin
                check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
                if (bus.mem_we) begin
                    check({tag, "_we_expected"}, {31'd0, q_addr.size() != 0}, 32'd1);
                    if (q_addr.size() != 0) begin
                        check({tag, "_mem_addr"}, bus.mem_addr, q_addr[0]);
                        check({tag, "_mem_wdata"}, {24'd0, bus.mem_wdata}, {24'd0, q_data[0]});
                    end
                end
            end
            case (mode)
                0:       bus.mem_ready = 1'b1;
                1:       bus.mem_ready = 1'($urandom_range(0, 1));
                default: bus.mem_ready = (stall >= 3);
            endcase
            if (bus.mem_we) stall++;
            if (!seen_done && bus.mem_we && bus.mem_ready && q_addr.size() != 0) begin
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
        end
        if (!seen_done) check({tag, "_timeout"}, 32'd0, 32'd1);
        bus.start = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        bus.start     = 1'b0;
        bus.funct3    = 3'd0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        rst = 1'b0;

        run_req(3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 0, "sw_basic");
        run_req(3'd0, 32'h0000_0203, 32'h1234_5678, 0, "sb_basic");
        run_req(3'd1, 32'h0000_0201, 32'h0000_BEEF, 0, "sh_misalign");
        run_req(3'd3, 32'h0000_0200, 32'h0000_BEEF, 0, "f3_illegal");
        run_req(3'd2, 32'h0000_0102, 32'hCAFE_F00D, 0, "sw_misalign");
        run_req(3'd1, 32'h0000_0040, 32'h0000_A55A, 2, "sh_stall");
        run_req(3'd2, 32'h0000_0080, 32'h0102_0304, 2, "sw_stall");

        // Reset in the middle of a word store drops the rest with no done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd2; bus.addr = 32'h300; bus.wdata = 32'h1122_3344;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_beat2_addr", bus.mem_addr, 32'h302);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_err", {31'd0, bus.err}, 32'd0);
        check("midrst_we", {31'd0, bus.mem_we}, 32'd0);
        check("midrst_addr", bus.mem_addr, 32'd0);
        check("midrst_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_quiet", {30'd0, bus.done, bus.mem_we}, 32'd0);
        end
        run_req(3'd0, 32'h0000_0305, 32'h0000_00A7, 0, "sb_after_rst");

        for (int t = 0; t < 40; t++) begin
            f3 = 3'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
            run_req(f3, a, $urandom, (t % 4 == 0) ? 0 : 1, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
